eth_tx_frame_buff: RTL

Multi-slot Ethernet TX frame buffer; next generation of the single dual-port TX byte RAM.
- CPU (Avalon-MM slave) fills the current write slot byte-by-byte, then commits it with a length.
- Committed frames queue in order and stream out on an Avalon-ST source to the MAC TX path, with backpressure.
- Replaces the bare RAM plus software polling with hardware slot management, framing (sop/eop) and error flags.

---
 rtl/eth_tx_buff_pkg.sv | 12 +
 rtl/eth_tx_buff_dpram.sv | 40 ++++
 rtl/eth_tx_frame_buff.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_buff_pkg.sv
// Shared types and constants for the multi-slot Ethernet TX frame buffer.
package eth_tx_buff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } strm_state_e;

  localparam int MIN_FRAME_LEN = 60;

endpackage

// File: rtl/eth_tx_buff_dpram.sv
// Simple dual-port byte RAM: port A is CPU read/write, port B is stream read-only.
// Both ports return data one cycle after the access.
module eth_tx_buff_dpram #(
  parameter int DATA_W = 8,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_a_en,
  input  logic              i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_en,
  input  logic [AW-1:0]     i_b_addr,
  output logic [DATA_W-1:0] o_b_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_a_q;
  logic [DATA_W-1:0] r_b_q;

  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wdata;
  end

  // CPU readback register is cleared so readdata is defined out of reset.
  always_ff @(posedge clk) begin
    if (i_rst)                    r_a_q <= '0;
    else if (i_a_en && !i_a_we)   r_a_q <= r_mem[i_a_addr];
  end

  always_ff @(posedge clk) begin
    if (i_b_en) r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/eth_tx_frame_buff.sv
// Multi-slot Ethernet TX frame buffer: CPU fills/commits slots, frames stream out in order.
// Optional short-frame zero padding to 60 bytes when ETH_TX_BUFF_PAD_EN is defined.
module eth_tx_frame_buff
  import eth_tx_buff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int SLOTS  = 2,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     commit,
  input  logic [LEN_W-1:0]         commit_len,
  output logic [$clog2(SLOTS):0]   free_slots,
  output logic                     commit_err,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_sop,
  output logic                     tx_eop
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int CNT_W  = $clog2(SLOTS) + 1;
  localparam int AW     = SLOT_W + ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

  logic [SLOT_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0]  r_used;
  logic              r_commit_err;
  logic [LEN_W-1:0]  r_len_tab [SLOTS];

  strm_state_e       r_state;
  logic [LEN_W-1:0]  r_len, r_rd_off, r_out_idx;
  logic              r_rd_vld;
  logic [1:0]        r_cnt;
  logic              r_head, r_tail;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_tx_valid, r_tx_sop, r_tx_eop;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_commit_ok, w_eop_xfer, w_start, w_active;
  logic [CNT_W-1:0]  w_used_nxt;
  logic [SLOT_W-1:0] w_start_slot;
  logic [LEN_W-1:0]  w_nbeats;
  logic              w_pad_byte, w_room, w_have, w_load, w_take, w_fifo_hit;
  logic              w_push, w_pop, w_issue;
  logic [2:0]        w_cnt_after;
  logic [DATA_W-1:0] w_ram_q, w_ld_data;
  logic [AW-1:0]     w_rd_addr;

  assign w_commit_ok = commit && (r_used < SLOTS_C) && (commit_len != '0) && (commit_len <= MAX_LEN);
  assign w_eop_xfer  = r_tx_valid && tx_ready && r_tx_eop;
  assign w_used_nxt  = r_used + CNT_W'(w_commit_ok) - CNT_W'(w_eop_xfer);
  assign w_active    = (r_state != IDLE);
  // A new frame starts from IDLE, or straight out of the eop beat so only the read latency separates frames.
  assign w_start      = ((r_state == IDLE) && (r_used != '0)) ||
                        ((r_state == STREAM) && w_eop_xfer && (w_used_nxt != '0));
  assign w_start_slot = (r_state == IDLE) ? r_rp : r_rp + SLOT_W'(1);

`ifdef ETH_TX_BUFF_PAD_EN
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
  assign w_nbeats   = (r_len < MIN_LEN) ? MIN_LEN : r_len;
  assign w_pad_byte = (r_out_idx >= r_len);
`else
  assign w_nbeats   = r_len;
  assign w_pad_byte = 1'b0;
`endif

  // Output register is fed from the skid FIFO head, or directly from RAM when the FIFO is empty.
  assign w_fifo_hit  = (r_cnt != 2'd0);
  assign w_room      = !r_tx_valid || tx_ready;
  assign w_have      = w_pad_byte || w_fifo_hit || r_rd_vld;
  assign w_load      = w_active && (r_out_idx < w_nbeats) && w_room && w_have;
  assign w_take      = w_load && !w_pad_byte;
  assign w_ld_data   = w_pad_byte ? '0 : (w_fifo_hit ? r_fifo[r_head] : w_ram_q);
  assign w_pop       = w_take && w_fifo_hit;
  assign w_push      = r_rd_vld && !(w_take && !w_fifo_hit);
  assign w_cnt_after = {1'b0, r_cnt} + {2'b0, r_rd_vld} - {2'b0, w_take};
  assign w_issue     = w_active && !w_start && (r_rd_off < r_len) && (w_cnt_after <= 3'd1);
  assign w_rd_addr   = w_start ? {w_start_slot, {ADDR_W{1'b0}}} : {r_rp, r_rd_off[ADDR_W-1:0]};

  eth_tx_buff_dpram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk      (clk),
    .i_rst    (reset),
    .i_a_en   (chipselect),
    .i_a_we   (write),
    .i_a_addr ({r_wp, address}),
    .i_a_wdata(writedata),
    .o_a_rdata(readdata),
    .i_b_en   (w_start || w_issue),
    .i_b_addr (w_rd_addr),
    .o_b_rdata(w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_used       <= '0;
      r_commit_err <= 1'b0;
    end else begin
      if (w_commit_ok) r_wp <= r_wp + SLOT_W'(1);
      if (w_eop_xfer)  r_rp <= r_rp + SLOT_W'(1);
      r_used <= w_used_nxt;
      if (commit && !w_commit_ok) r_commit_err <= 1'b1;
      else if (err_clr)           r_commit_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit_ok) r_len_tab[r_wp] <= commit_len;
    if (w_push)      r_fifo[r_tail]  <= w_ram_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_rd_off   <= '0;
      r_out_idx  <= '0;
      r_rd_vld   <= 1'b0;
      r_cnt      <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_start) r_state <= FETCH;
        FETCH:   r_state <= STREAM;
        STREAM:  if (w_eop_xfer) r_state <= w_start ? FETCH : IDLE;
        default: r_state <= IDLE;
      endcase

      r_rd_vld <= w_start || w_issue;
      r_cnt    <= w_cnt_after[1:0];
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;

      if (w_start) begin
        r_len     <= r_len_tab[w_start_slot];
        r_rd_off  <= LEN_W'(1);
        r_out_idx <= '0;
      end else begin
        if (w_issue) r_rd_off  <= r_rd_off + LEN_W'(1);
        if (w_load)  r_out_idx <= r_out_idx + LEN_W'(1);
      end

      if (w_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_ld_data;
        r_tx_sop   <= (r_out_idx == '0);
        r_tx_eop   <= (r_out_idx == w_nbeats - LEN_W'(1));
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
        r_tx_sop   <= 1'b0;
        r_tx_eop   <= 1'b0;
      end
    end
  end

  assign free_slots = SLOTS_C - r_used;
  assign commit_err = r_commit_err;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign tx_sop     = r_tx_sop;
  assign tx_eop     = r_tx_eop;

endmodule
